interp_upsampler: RTL and testbench

- Linear-interpolating upsampler for signed audio samples. It is the expansion counterpart to the moving-average smoothing filter.
- Accepts one input sample per handshake and emits L interpolated samples that ramp from the previous input to the new one. L = 2/4/8/16.
- Sits between a low-rate sample source and a high-rate consumer. Valid/ready handshake on both sides.

---
 rtl/interp_upsampler.sv | 139 +++++++++++++
 tb/tb_interp_upsampler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interp_upsampler.sv
// interp_upsampler: signed linear-interpolating upsampler (x2/x4/x8/x16).
// Define INTERP_ROUND_EN for round-half-up steps instead of floor.
module interp_upsampler #(
   parameter int BIT_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        sclr,
   input  logic [2:0]                  interp_sel,
   input  logic signed [BIT_WIDTH-1:0] d,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic signed [BIT_WIDTH-1:0] q,
   output logic                        out_valid,
   input  logic                        out_ready
);

   localparam int PW = BIT_WIDTH + 6;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t                      state_q, state_d;
   logic signed [BIT_WIDTH-1:0] prev_q, prev_d;
   logic signed [BIT_WIDTH-1:0] cur_q, cur_d;
   logic signed [BIT_WIDTH-1:0] q_q, q_d;
   logic [4:0]                  k_q, k_d;
   logic [2:0]                  s_q, s_d;
   logic                        out_valid_q, out_valid_d;

   logic [2:0] sel_s;
   logic [4:0] len;
   logic       last;
   logic       accept;
   logic       adv;

   // prev + ((cur - prev) * k) >>> s, optionally rounded half-up
   function automatic logic signed [BIT_WIDTH-1:0] interp(
      input logic signed [BIT_WIDTH-1:0] p,
      input logic signed [BIT_WIDTH-1:0] c,
      input logic [4:0]                  k,
      input logic [2:0]                  s
   );
      logic signed [BIT_WIDTH:0] diff;
      logic signed [PW-1:0]      prod;
      logic signed [PW-1:0]      stp;
`ifdef INTERP_ROUND_EN
      logic signed [PW-1:0]      rnd;
`endif
      diff = {c[BIT_WIDTH-1], c} - {p[BIT_WIDTH-1], p};
      prod = PW'(diff) * PW'($signed({1'b0, k}));
`ifdef INTERP_ROUND_EN
      rnd  = PW'(1) << (s - 3'd1);
      prod = prod + rnd;
`endif
      stp  = prod >>> s;
      return p + stp[BIT_WIDTH-1:0];
   endfunction

   // factor select to log2(L)
   always_comb begin
      unique case (interp_sel)
         3'b000:  sel_s = 3'd1;
         3'b001:  sel_s = 3'd2;
         3'b010:  sel_s = 3'd3;
         default: sel_s = 3'd4;
      endcase
   end

   // handshake qualifiers; in_ready follows out_ready on the last sample
   always_comb begin
      len      = 5'd1 << s_q;
      last     = (state_q == RUN) && (k_q == len);
      in_ready = !sclr && ((state_q == IDLE) || (last && out_ready));
      accept   = in_valid && in_ready;
      adv      = (state_q == RUN) && out_ready && !last;
   end

   // next-state: clear, accept/restart, advance, or finish the burst
   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      cur_d       = cur_q;
      q_d         = q_q;
      k_d         = k_q;
      s_d         = s_q;
      out_valid_d = out_valid_q;
      if (sclr) begin
         state_d     = IDLE;
         prev_d      = '0;
         cur_d       = '0;
         q_d         = '0;
         k_d         = '0;
         s_d         = '0;
         out_valid_d = 1'b0;
      end else if (accept) begin
         state_d     = RUN;
         prev_d      = cur_q;
         cur_d       = d;
         s_d         = sel_s;
         k_d         = 5'd1;
         out_valid_d = 1'b1;
         q_d         = interp(cur_q, d, 5'd1, sel_s);
      end else if (adv) begin
         k_d = k_q + 5'd1;
         q_d = interp(prev_q, cur_q, k_q + 5'd1, s_q);
      end else if (last && out_ready) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
      end
   end

   // state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         prev_q      <= '0;
         cur_q       <= '0;
         q_q         <= '0;
         k_q         <= '0;
         s_q         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         cur_q       <= cur_d;
         q_q         <= q_d;
         k_q         <= k_d;
         s_q         <= s_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign q         = q_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_interp_upsampler.sv
// tb_interp_upsampler: table vectors, corner sequences and a
// randomized run against an arithmetic reference model.
`timescale 1ns/1ps
module tb_interp_upsampler;

   localparam int W = 16;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                sclr = 1'b0;
   logic [2:0]          interp_sel = 3'd0;
   logic signed [W-1:0] d = '0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic signed [W-1:0] q;
   logic                out_valid;
   logic                out_ready = 1'b0;

   int n_run = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   interp_upsampler #(.BIT_WIDTH(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sclr(sclr),
      .interp_sel(interp_sel),
      .d(d),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .q(q),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   typedef struct {
      bit s;
      bit iv;
      int dv;
      int sel;
      bit ordy;
      bit cir;
      bit ir;
      bit ov;
      int qv;
   } vec_t;

   vec_t tbl[$];

   function automatic int fdiv(int a, int b);
      int r;
      r = a / b;
      if ((a % b) != 0 && a < 0) r = r - 1;
      return r;
   endfunction

   function automatic int lfac(int sel);
      if (sel == 0) return 2;
      if (sel == 1) return 4;
      if (sel == 2) return 8;
      return 16;
   endfunction

   // k-th of l evenly spaced points from p towards c
   function automatic int ref_q(int p, int c, int k, int l);
      int a;
      a = (c - p) * k;
`ifdef INTERP_ROUND_EN
      return p + fdiv(a + l / 2, l);
`else
      return p + fdiv(a, l);
`endif
   endfunction

   function automatic vec_t v(bit s, bit iv, int dv, int sel, bit ordy,
                              bit cir, bit ir, bit ov, int qv);
      vec_t r;
      r.s = s; r.iv = iv; r.dv = dv; r.sel = sel; r.ordy = ordy;
      r.cir = cir; r.ir = ir; r.ov = ov; r.qv = qv;
      return r;
   endfunction

   task automatic chk(string nm, int act, int exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(bit s, bit iv, int dv, int sl, bit ordy);
      @(negedge clk);
      sclr       = s;
      in_valid   = iv;
      d          = W'(dv);
      interp_sel = 3'(sl);
      out_ready  = ordy;
      #1;
   endtask

   initial begin
      int fr[4];
      int last;
      int mcur;
      int exq[$];
      bit rs, iv, ordy, eir;
      int dv, sl, r, l;

`ifdef INTERP_ROUND_EN
      fr[0] = 0; fr[1] = 0; fr[2] = -1; fr[3] = -1;
`else
      fr[0] = -1; fr[1] = -1; fr[2] = -1; fr[3] = -1;
`endif
      // x4 ramp 0->100, then back-to-back 100->-100
      tbl.push_back(v(0, 1, 100, 1, 1, 1, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 1, 1, 1, 0, 1, 25));
      tbl.push_back(v(0, 0, 0, 1, 1, 1, 0, 1, 50));
      tbl.push_back(v(0, 0, 0, 1, 1, 1, 0, 1, 75));
      tbl.push_back(v(0, 1, -100, 1, 1, 1, 1, 1, 100));
      tbl.push_back(v(0, 0, 0, 1, 1, 1, 0, 1, 50));
      tbl.push_back(v(0, 0, 0, 1, 1, 1, 0, 1, 0));
      tbl.push_back(v(0, 0, 0, 1, 1, 1, 0, 1, -50));
      tbl.push_back(v(0, 0, 0, 1, 1, 1, 1, 1, -100));
      tbl.push_back(v(0, 0, 0, 1, 1, 1, 1, 0, 0));
      // sclr wins over an offered input, then floor/round of -1
      tbl.push_back(v(1, 1, 500, 1, 1, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 1, 1, 1, 1, 0, 0));
      tbl.push_back(v(0, 1, -1, 1, 1, 1, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 1, 1, 1, 0, 1, fr[0]));
      tbl.push_back(v(0, 0, 0, 1, 1, 1, 0, 1, fr[1]));
      tbl.push_back(v(0, 0, 0, 1, 1, 1, 0, 1, fr[2]));
      tbl.push_back(v(0, 0, 0, 1, 1, 1, 1, 1, fr[3]));
      tbl.push_back(v(0, 0, 0, 1, 1, 1, 1, 0, 0));
      // backpressure on x2 ramp 0->1000
      tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 1000, 0, 1, 1, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 1, 500));
      tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 1, 500));
      tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 1, 500));
      tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 1, 500));
      tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 1, 1000));
      tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 0, 0));

      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_q", q, 0);
      chk("reset_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].s, tbl[i].iv, tbl[i].dv, tbl[i].sel, tbl[i].ordy);
         if (tbl[i].cir)
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].ir);
         chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
         if (tbl[i].ov)
            chk($sformatf("tbl%0d_q", i), q, tbl[i].qv);
      end

      // full-scale x16 ramp from -32768 to 32767
      step(1, 0, 0, 0, 1);
      step(0, 1, -32768, 0, 1);
      chk("ext_pre_accept", in_ready, 1);
      step(0, 0, 0, 0, 1);
      chk("ext_pre_q1", q, -16384);
      step(0, 1, 32767, 3, 1);
      chk("ext_pre_q2", q, -32768);
      chk("ext_b2b_ready", in_ready, 1);
      last = -32768;
      for (int i = 1; i <= 16; i++) begin
         step(0, 0, 0, 0, 1);
         chk($sformatf("ext_ov%0d", i), out_valid, 1);
         chk($sformatf("ext_q%0d", i), q, ref_q(-32768, 32767, i, 16));
         chk($sformatf("ext_mono%0d", i), (int'(q) > last), 1);
         last = q;
      end
`ifdef INTERP_ROUND_EN
      chk("ext_first", ref_q(-32768, 32767, 1, 16), -28672);
`else
      chk("ext_first", ref_q(-32768, 32767, 1, 16), -28673);
`endif
      chk("ext_last", last, 32767);

      // async reset mid x8 burst, then a sel change mid-burst
      step(1, 0, 0, 2, 1);
      step(0, 1, 800, 2, 1);
      step(0, 0, 0, 2, 1);
      chk("mid_q1", q, 100);
      step(0, 0, 0, 2, 1);
      chk("mid_q2", q, 200);
      step(0, 0, 0, 2, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ov", out_valid, 0);
      chk("mid_rst_q", q, 0);
      #1;
      rst_n = 1'b1;
      step(0, 1, 80, 2, 1);
      chk("mid_accept", in_ready, 1);
      chk("mid_accept_ov", out_valid, 0);
      for (int i = 1; i <= 8; i++) begin
         step(0, 0, 0, (i >= 3) ? 0 : 2, 1);
         chk($sformatf("sel_ov%0d", i), out_valid, 1);
         chk($sformatf("sel_q%0d", i), q, ref_q(0, 80, i, 8));
         chk($sformatf("sel_ir%0d", i), in_ready, (i == 8) ? 1 : 0);
      end
      step(0, 0, 0, 0, 1);
      chk("sel_done_ov", out_valid, 0);

      // randomized traffic against the queue model
      step(1, 0, 0, 0, 1);
      mcur = 0;
      exq.delete();
      for (int c = 0; c < 4000; c++) begin
         rs   = ($urandom_range(0, 99) == 0);
         iv   = ($urandom_range(0, 2) != 0);
         sl   = $urandom_range(0, 7);
         ordy = ($urandom_range(0, 3) != 0);
         r    = $urandom_range(0, 9);
         if (r == 0) dv = -32768;
         else if (r == 1) dv = 32767;
         else dv = int'($signed(W'($urandom)));
         step(rs, iv, dv, sl, ordy);
         if (rs) begin
            exq.delete();
            mcur = 0;
         end else begin
            eir = (exq.size() == 0) || (exq.size() == 1 && ordy);
            chk("rnd_in_ready", in_ready, eir);
            chk("rnd_out_valid", out_valid, exq.size() != 0);
            if (exq.size() != 0) begin
               chk("rnd_q", q, exq[0]);
               if (ordy) void'(exq.pop_front());
            end
            if (iv && eir) begin
               l = lfac(sl);
               for (int k = 1; k <= l; k++)
                  exq.push_back(ref_q(mcur, dv, k, l));
               mcur = dv;
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
